hazard_unit_hfnc: RTL and testbench
===================================

# hazard_unit_hfnc

Issue-side hazard detector and hash-unit scoreboard for the five-stage hash processor pipeline. Sits between IF/ID and ID/EX. It stalls the front end on load-use hazards and on dependencies against the single multi-cycle hash-function (HFnc) operation in flight. It also sequences that operation's completion and emits its writeback strobe. It handles the cases the forwarding logic cannot cover, and hands the hash result to the writeback path.

## Interface
- `HFNC_LATENCY`, default 4: cycles from hash issue to writeback strobe; legal range 2..15.
- `CNT_W`, default 16: width of the stall performance counter.

- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_id_RegisterRs`, `if_id_RegisterRt`, `if_id_RegisterRu`  in  5 each  source registers of the instruction in ID.
- `if_id_UsesRs`, `if_id_UsesRt`, `if_id_UsesRu`  in  1 each  the corresponding source is actually read.
- `if_id_IsHFnc`  in  1  ID instruction is a hash op.
- `if_id_RegisterRd`  in  5  destination of the ID instruction.
- `if_id_Flush`  in  1  ID instruction is being squashed (taken branch); treated as invalid.
- `id_ex_MemRead`  in  1  instruction in EX is a load.
- `id_ex_RegisterRd`  in  5  destination of the instruction in EX.
- `PCWrite`  out  1  PC update enable.
- `IF_ID_Write`  out  1  IF/ID register enable.
- `ID_EX_Bubble`  out  1  zero control bits into ID/EX this cycle.
- `hf_busy`  out  1  hash op outstanding.
- `hf_wb`  out  1  one-cycle hash writeback strobe.
- `hf_wb_rd`  out  5  destination register for `hf_wb`.
- `stall_cnt`  out  CNT_W  saturating count of stall cycles (see Configuration).

## Operation
- State: `busy` (1b), `cnt` (4b), `rd_q` (5b). States: IDLE (`busy`=0) and RUN (`busy`=1).
- `src_hit(r)` = Uses bit set, register != 0, and register == r; evaluated for each of Rs, Rt, Ru.
- `load_use` = `id_ex_MemRead` and `id_ex_RegisterRd` != 0 and `src_hit(id_ex_RegisterRd)` for any source.
- `hf_dep` = `busy` and `rd_q` != 0 and `src_hit(rd_q)` for any source.
- `hf_struct` = `busy` and `if_id_IsHFnc`.
- `stall` = not `if_id_Flush` and (`load_use` or `hf_dep` or `hf_struct`).
- Stall outputs: `PCWrite` = `IF_ID_Write` = not `stall`; `ID_EX_Bubble` = `stall`.
- `issue` = `if_id_IsHFnc` and not `if_id_Flush` and not `stall`.
- IDLE to RUN on `issue`: `cnt` <= `HFNC_LATENCY`, `rd_q` <= `if_id_RegisterRd`.
- RUN: `cnt` decrements each cycle. When `cnt`==1, `hf_wb`=1 and `hf_wb_rd`=`rd_q`. Next cycle: `cnt`=0, `busy`=0, return to IDLE.
- A new issue cannot occur in the `cnt`==1 cycle, because `hf_struct` blocks it. Back-to-back hash ops are therefore separated by at least `HFNC_LATENCY`+1 cycles.
- Hash op with Rd=0: occupies the unit and strobes `hf_wb` with `hf_wb_rd`=0. Never causes a data stall.
- `hf_wb_rd` holds `rd_q` at all times; `hf_wb` is the qualifier.
- `if_id_Flush` overrides all stall terms and suppresses issue. Running hash ops are unaffected.

## Timing
- Stall outputs are combinational from inputs and state, with zero latency.
- Issue in cycle T gives `hf_busy`=1 from T+1 through T+`HFNC_LATENCY`, and `hf_wb` in cycle T+`HFNC_LATENCY`.
- A dependent instruction in ID stalls through T+`HFNC_LATENCY` and proceeds at T+`HFNC_LATENCY`+1. The register file writes through, so it reads the new value.
- Load-use stalls last exactly one cycle, since the load leaves EX.
- Reset values: `busy`=0, `cnt`=0, `rd_q`=0, `hf_wb`=0, `hf_wb_rd`=0, `stall_cnt`=0. With quiet inputs, `PCWrite`=1, `IF_ID_Write`=1, `ID_EX_Bubble`=0.
- `rst` mid-RUN aborts the operation immediately; no `hf_wb` is emitted.

## Configuration
- `HAZ_STALL_CNT_EN` defined: `stall_cnt` increments on every cycle with `stall`=1, saturating at all-ones. It is cleared only by `rst`.
- Not defined: no counter register is built, and `stall_cnt` is tied to 0.

## Test plan
- Load-use: `id_ex_MemRead`=1, `id_ex_RegisterRd`=5, ID Rs=5 used -> exactly 1 cycle of `PCWrite`=0 and `ID_EX_Bubble`=1. With Rd=0 -> no stall.
- Hash dependency, LAT=4: issue with Rd=7 at T, dependent Ru=7 held in ID -> stall T+1..T+4, `hf_wb`=1 with `hf_wb_rd`=7 at T+4, proceeds at T+5.
- Structural: second hash op in ID while busy -> stalled until `hf_busy`=0; issues at T+5; next `hf_wb` at T+9.
- Flush: `if_id_Flush`=1 with a dependent hash op in ID while busy -> no stall, no issue, and the first op still completes at T+4.
- Reset at T+2 of a running op -> `hf_busy`=0 and no `hf_wb` in any cycle; outputs at reset values.
- With `HAZ_STALL_CNT_EN`: 3 stall cycles -> `stall_cnt`=3. With `CNT_W`=2 and 5 stalls -> saturates at 3. Without the macro -> 0.

Source files
------------

// File: rtl/hazard_unit_hfnc.sv
// ---------------------------------------------------------------------------
// hazard_unit_hfnc
//
// Issue-side hazard detector and hash-unit scoreboard for the five-stage hash
// processor pipeline, sitting between IF/ID and ID/EX.
//   * Stalls the front end on load-use hazards, on data dependencies against
//     the single in-flight hash-function (HFnc) operation, and on a second
//     hash op arriving while the unit is busy.
//   * Sequences the in-flight hash op and emits its one-cycle writeback strobe.
//
// Parameters
//   HFNC_LATENCY  cycles from hash issue to writeback strobe (2..15)
//   CNT_W         width of the stall performance counter
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   if_id_Register{Rs,Rt,Ru}     source registers of the ID instruction
//   if_id_Uses{Rs,Rt,Ru}         source actually read
//   if_id_IsHFnc                 ID instruction is a hash op
//   if_id_RegisterRd             destination of the ID instruction
//   if_id_Flush                  ID instruction is squashed
//   id_ex_MemRead                EX instruction is a load
//   id_ex_RegisterRd             destination of the EX instruction
//   PCWrite, IF_ID_Write         front-end enables (low while stalling)
//   ID_EX_Bubble                 inject a bubble into ID/EX
//   hf_busy                      hash op outstanding
//   hf_wb, hf_wb_rd              hash writeback strobe and its destination
//   stall_cnt                    saturating stall-cycle counter
//
// Build option
//   HAZ_STALL_CNT_EN  when defined, stall_cnt counts stall cycles and
//                     saturates at all-ones; otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module hazard_unit_hfnc #(
  parameter int HFNC_LATENCY = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       if_id_RegisterRs,
  input  logic [4:0]       if_id_RegisterRt,
  input  logic [4:0]       if_id_RegisterRu,
  input  logic             if_id_UsesRs,
  input  logic             if_id_UsesRt,
  input  logic             if_id_UsesRu,
  input  logic             if_id_IsHFnc,
  input  logic [4:0]       if_id_RegisterRd,
  input  logic             if_id_Flush,
  input  logic             id_ex_MemRead,
  input  logic [4:0]       id_ex_RegisterRd,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Bubble,
  output logic             hf_busy,
  output logic             hf_wb,
  output logic [4:0]       hf_wb_rd,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] rd_q, rd_d;

  logic busy;
  logic load_use;
  logic hf_dep;
  logic hf_struct;
  logic stall;
  logic issue;

  // A source matches r only if it is really read and is not the zero
  // register, which never carries a dependency.
  function automatic logic src_hit(input logic       uses,
                                   input logic [4:0] src,
                                   input logic [4:0] r);
    return uses && (src != 5'd0) && (src == r);
  endfunction

  function automatic logic any_src_hit(input logic [4:0] r,
                                       input logic       us_rs,
                                       input logic [4:0] rs,
                                       input logic       us_rt,
                                       input logic [4:0] rt,
                                       input logic       us_ru,
                                       input logic [4:0] ru);
    return src_hit(us_rs, rs, r) || src_hit(us_rt, rt, r) || src_hit(us_ru, ru, r);
  endfunction

  assign busy = (state_q == RUN);

  // Hazard terms and stall decision: purely combinational, zero latency.
  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (defaults first) so no latch is inferred.
  always_comb begin
    load_use  = 1'b0;
    hf_dep    = 1'b0;
    hf_struct = 1'b0;
    stall     = 1'b0;
    issue     = 1'b0;

    load_use = id_ex_MemRead && (id_ex_RegisterRd != 5'd0) &&
               any_src_hit(id_ex_RegisterRd,
                           if_id_UsesRs, if_id_RegisterRs,
                           if_id_UsesRt, if_id_RegisterRt,
                           if_id_UsesRu, if_id_RegisterRu);

    hf_dep = busy && (rd_q != 5'd0) &&
             any_src_hit(rd_q,
                         if_id_UsesRs, if_id_RegisterRs,
                         if_id_UsesRt, if_id_RegisterRt,
                         if_id_UsesRu, if_id_RegisterRu);

    // Only one hash op may be outstanding; this also blocks issue in the
    // writeback cycle, so back-to-back ops are LAT+1 cycles apart.
    hf_struct = busy && if_id_IsHFnc;

    // A squashed instruction never stalls and never issues.
    stall = !if_id_Flush && (load_use || hf_dep || hf_struct);
    issue = if_id_IsHFnc && !if_id_Flush && !stall;
  end

  assign PCWrite      = !stall;
  assign IF_ID_Write  = !stall;
  assign ID_EX_Bubble = stall;

  // Hash-unit sequencer: next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = RUN;
          cnt_d   = 4'(HFNC_LATENCY);
          rd_d    = if_id_RegisterRd;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  assign hf_busy  = busy;
  assign hf_wb    = busy && (cnt_q == 4'd1);
  // rd_q is held after completion; hf_wb qualifies it.
  assign hf_wb_rd = rd_q;

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_hfnc.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit_hfnc
//
// Self-checking bench for hazard_unit_hfnc. The reference model tracks the
// cycle number in which the outstanding hash op issued; busy and writeback
// follow from that cycle number by plain arithmetic. Two instances are
// driven in parallel: the default counter width and a 2-bit counter that
// exercises saturation.
// ---------------------------------------------------------------------------
module tb_hazard_unit_hfnc;

  localparam int LAT = 4;
  localparam int CW  = 16;
  localparam int CW2 = 2;

  logic clk = 1'b0;
  logic rst;

  logic [4:0] rs, rt, ru, rd, ex_rd;
  logic       us, ut, uu, is_hf, flush, mem_rd;

  logic          pc_write, ifid_write, bubble, hf_busy, hf_wb;
  logic [4:0]    hf_wb_rd;
  logic [CW-1:0] stall_cnt;

  logic           pc_write2, ifid_write2, bubble2, hf_busy2, hf_wb2;
  logic [4:0]     hf_wb_rd2;
  logic [CW2-1:0] stall_cnt2;

  hazard_unit_hfnc #(.HFNC_LATENCY(LAT), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst),
    .if_id_RegisterRs(rs), .if_id_RegisterRt(rt), .if_id_RegisterRu(ru),
    .if_id_UsesRs(us), .if_id_UsesRt(ut), .if_id_UsesRu(uu),
    .if_id_IsHFnc(is_hf), .if_id_RegisterRd(rd), .if_id_Flush(flush),
    .id_ex_MemRead(mem_rd), .id_ex_RegisterRd(ex_rd),
    .PCWrite(pc_write), .IF_ID_Write(ifid_write), .ID_EX_Bubble(bubble),
    .hf_busy(hf_busy), .hf_wb(hf_wb), .hf_wb_rd(hf_wb_rd),
    .stall_cnt(stall_cnt)
  );

  hazard_unit_hfnc #(.HFNC_LATENCY(LAT), .CNT_W(CW2)) u_dut_sat (
    .clk(clk), .rst(rst),
    .if_id_RegisterRs(rs), .if_id_RegisterRt(rt), .if_id_RegisterRu(ru),
    .if_id_UsesRs(us), .if_id_UsesRt(ut), .if_id_UsesRu(uu),
    .if_id_IsHFnc(is_hf), .if_id_RegisterRd(rd), .if_id_Flush(flush),
    .id_ex_MemRead(mem_rd), .id_ex_RegisterRd(ex_rd),
    .PCWrite(pc_write2), .IF_ID_Write(ifid_write2), .ID_EX_Bubble(bubble2),
    .hf_busy(hf_busy2), .hf_wb(hf_wb2), .hf_wb_rd(hf_wb_rd2),
    .stall_cnt(stall_cnt2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state.
  logic       op_valid = 1'b0;
  int         t_issue  = -100;
  logic [4:0] m_rd     = 5'd0;
  longint     n_stall  = 0;
  logic       m_stall, m_issue;

  // Observations of the most recent cycle, for directed sequence checks.
  logic       obs_stall, obs_wb;
  logic [4:0] obs_wb_rd;

  logic [4:0] pool [6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic hit(input logic [4:0] r);
    return (us && rs != 5'd0 && rs == r) ||
           (ut && rt != 5'd0 && rt == r) ||
           (uu && ru != 5'd0 && ru == r);
  endfunction

  function automatic longint sat(input longint n, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic quiet();
    rs = 5'd0; rt = 5'd0; ru = 5'd0; rd = 5'd0; ex_rd = 5'd0;
    us = 1'b0; ut = 1'b0; uu = 1'b0; is_hf = 1'b0; flush = 1'b0; mem_rd = 1'b0;
  endtask

  // Called one time unit after a rising edge with inputs already driven.
  // Compares both instances against the model, advances one clock, then
  // updates the model with the decision taken in that cycle.
  task automatic apply_cycle();
    logic m_busy, m_wb, lu, dep, st;
    longint e1, e2;
    #2;
    m_busy  = op_valid && (cyc > t_issue) && (cyc <= t_issue + LAT);
    m_wb    = op_valid && (cyc == t_issue + LAT);
    lu      = mem_rd && (ex_rd != 5'd0) && hit(ex_rd);
    dep     = m_busy && (m_rd != 5'd0) && hit(m_rd);
    st      = m_busy && is_hf;
    m_stall = !flush && (lu || dep || st);
    m_issue = is_hf && !flush && !m_stall;
`ifdef HAZ_STALL_CNT_EN
    e1 = sat(n_stall, CW);
    e2 = sat(n_stall, CW2);
`else
    e1 = 0;
    e2 = 0;
`endif
    check("PCWrite",      32'(pc_write),   32'(!m_stall));
    check("IF_ID_Write",  32'(ifid_write), 32'(!m_stall));
    check("ID_EX_Bubble", 32'(bubble),     32'(m_stall));
    check("hf_busy",      32'(hf_busy),    32'(m_busy));
    check("hf_wb",        32'(hf_wb),      32'(m_wb));
    check("hf_wb_rd",     32'(hf_wb_rd),   32'(m_rd));
    check("stall_cnt",    32'(stall_cnt),  32'(e1));
    check("sat_PCWrite",  32'(pc_write2),  32'(!m_stall));
    check("sat_IF_ID",    32'(ifid_write2), 32'(!m_stall));
    check("sat_Bubble",   32'(bubble2),    32'(m_stall));
    check("sat_hf_busy",  32'(hf_busy2),   32'(m_busy));
    check("sat_hf_wb",    32'(hf_wb2),     32'(m_wb));
    check("sat_hf_wb_rd", 32'(hf_wb_rd2),  32'(m_rd));
    check("sat_stall_cnt", 32'(stall_cnt2), 32'(e2));
    obs_stall = !pc_write;
    obs_wb    = hf_wb;
    obs_wb_rd = hf_wb_rd;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      if (m_issue) begin
        op_valid = 1'b1;
        t_issue  = cyc - 1;
        m_rd     = rd;
      end
      if (m_stall) n_stall++;
    end
    #1;
  endtask

  // Asserts reset mid-cycle, checks the reset values, releases after the edge.
  task automatic do_reset();
    rst = 1'b1;
    quiet();
    op_valid = 1'b0;
    m_rd     = 5'd0;
    n_stall  = 0;
    apply_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, wbk;
    logic [4:0] wbr;
    pool = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd7};

    quiet();
    do_reset();
    do_reset();

    // Load-use: exactly one stall cycle, then the load has left EX.
    quiet(); mem_rd = 1'b1; ex_rd = 5'd5; rs = 5'd5; us = 1'b1;
    apply_cycle(); n = int'(obs_stall);
    mem_rd = 1'b0;
    apply_cycle(); n += int'(obs_stall);
    check("loaduse_len", 32'(n), 32'd1);
    quiet(); mem_rd = 1'b1; ex_rd = 5'd0; rs = 5'd0; us = 1'b1;
    apply_cycle();
    check("loaduse_r0", 32'(obs_stall), 32'd0);

    // Hash dependency: dependent Ru held in ID until the result is written.
    quiet(); is_hf = 1'b1; rd = 5'd7;
    apply_cycle();
    quiet(); uu = 1'b1; ru = 5'd7; n = 0; wbk = -1; wbr = 5'd0;
    for (int k = 1; k <= LAT + 3; k++) begin
      apply_cycle();
      if (obs_wb) begin wbk = k; wbr = obs_wb_rd; end
      if (obs_stall) n++;
      else break;
    end
    check("dep_stall_len", 32'(n), 32'(LAT));
    check("dep_wb_cycle", 32'(wbk), 32'(LAT));
    check("dep_wb_rd", 32'(wbr), 32'd7);

    // Structural: second hash op waits for the unit.
    quiet(); is_hf = 1'b1; rd = 5'd3;
    apply_cycle();
    rd = 5'd9; wbk = -1;
    for (int k = 1; k <= LAT + 3; k++) begin
      apply_cycle();
      if (!obs_stall) begin wbk = k; break; end
    end
    check("struct_issue_cycle", 32'(wbk), 32'(LAT + 1));
    quiet(); wbk = -1; wbr = 5'd0;
    for (int k = LAT + 2; k <= 3 * LAT; k++) begin
      apply_cycle();
      if (obs_wb) begin wbk = k; wbr = obs_wb_rd; break; end
    end
    check("struct_wb2_cycle", 32'(wbk), 32'(2 * LAT + 1));
    check("struct_wb2_rd", 32'(wbr), 32'd9);
    repeat (LAT) apply_cycle();

    // Flush overrides the dependency and the structural hazard.
    quiet(); is_hf = 1'b1; rd = 5'd7;
    apply_cycle();
    flush = 1'b1; is_hf = 1'b1; rd = 5'd4; uu = 1'b1; ru = 5'd7;
    apply_cycle();
    check("flush_nostall", 32'(obs_stall), 32'd0);
    quiet(); wbk = -1; wbr = 5'd0;
    for (int k = 2; k <= LAT + 2; k++) begin
      apply_cycle();
      if (obs_wb) begin wbk = k; wbr = obs_wb_rd; end
    end
    check("flush_wb_cycle", 32'(wbk), 32'(LAT));
    check("flush_wb_rd", 32'(wbr), 32'd7);

    // Reset two cycles into a running op: no writeback ever appears.
    quiet(); is_hf = 1'b1; rd = 5'd6;
    apply_cycle();
    quiet();
    apply_cycle();
    do_reset();
    n = int'(obs_wb);
    for (int k = 0; k <= LAT + 2; k++) begin
      apply_cycle();
      n += int'(obs_wb);
    end
    check("rst_no_wb", 32'(n), 32'd0);

    // Five stall cycles: full-width counter reads 5, 2-bit counter sticks at 3.
    quiet(); mem_rd = 1'b1; ex_rd = 5'd2; rt = 5'd2; ut = 1'b1;
    repeat (5) apply_cycle();
`ifdef HAZ_STALL_CNT_EN
    check("stall_cnt_5", 32'(stall_cnt), 32'd5);
    check("stall_cnt_sat", 32'(stall_cnt2), 32'd3);
`else
    check("stall_cnt_off", 32'(stall_cnt), 32'd0);
    check("stall_cnt_sat_off", 32'(stall_cnt2), 32'd0);
`endif

    // Randomized traffic over a small register pool to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      rs     = pool[$urandom_range(0, 5)];
      rt     = pool[$urandom_range(0, 5)];
      ru     = pool[$urandom_range(0, 5)];
      rd     = pool[$urandom_range(0, 5)];
      ex_rd  = pool[$urandom_range(0, 5)];
      us     = ($urandom_range(0, 1) == 0);
      ut     = ($urandom_range(0, 1) == 0);
      uu     = ($urandom_range(0, 1) == 0);
      is_hf  = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 9) == 0);
      mem_rd = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      else apply_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
